// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: word type, FSM state and owner enums.
// Optional feature macro used by this block: ARB_FAIR_EN (instruction starvation guard).
package mem_bus_arbiter_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned STARVE_CNT_W = 3;

  typedef logic [WORD_W-1:0]       word_t;
  typedef logic [STARVE_CNT_W-1:0] starve_cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_grant_sel.sv
// Winner selection between the instruction and data requesters.
// Data wins by default; with ARB_FAIR_EN defined, instruction wins once the
// starve count reaches STARVE_MAX while both requests are pending.
module arb_grant_sel
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                    i_req,
  input  logic                    d_req,
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
  output arb_owner_t              winner
);

`ifndef ARB_FAIR_EN
  // Strict data priority never looks at the starve count.
  logic unused_cnt;
  assign unused_cnt = (^starve_cnt) ^ (STARVE_MAX == 32'd0);
`endif

  // Pick the owner for the next transaction.
  always_comb begin
    winner = OWN_D;
`ifdef ARB_FAIR_EN
    if (i_req && d_req && (starve_cnt == STARVE_CNT_W'(STARVE_MAX))) begin
      winner = OWN_I;
    end else if (d_req) begin
      winner = OWN_D;
    end else if (i_req) begin
      winner = OWN_I;
    end
`else
    if (!d_req && i_req) begin
      winner = OWN_I;
    end
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one sram-like bus port between the fetch (i_*) and memory-stage (d_*)
// masters, one transaction outstanding at a time, data preferred.
// Optional feature macro: ARB_FAIR_EN (bounded instruction starvation).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [1:0]        i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_t              state, state_nxt;
  arb_owner_t              owner;
  arb_owner_t              winner;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    any_req;
  logic                    grant;

  assign any_req = i_req | d_req;
  assign grant   = (state == IDLE) && any_req;

  arb_grant_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant_sel (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt),
    .winner     (winner)
  );

  // State and owner registers; owner is latched only at the arbitration cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= OWN_D;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner <= winner;
      end
    end
  end

`ifdef ARB_FAIR_EN
  // Count data grants taken while fetch waits; an instruction grant clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (winner == OWN_I) begin
        starve_cnt <= '0;
      end else if (i_req && (starve_cnt != STARVE_CNT_W'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end
`else
  assign starve_cnt = '0;
`endif

  // Next-state: IDLE arbitrates, ADDR waits for bus accept, DATA waits for bus ack.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)   state_nxt = ADDR;
      ADDR:    if (m_addr_ok) state_nxt = DATA;
      DATA:    if (m_data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus fields muxed from the owner in ADDR only; handshakes routed to the owner.
  always_comb begin
    m_req     = 1'b0;
    m_wr      = 1'b0;
    m_size    = '0;
    m_addr    = '0;
    m_wdata   = '0;
    i_addr_ok = 1'b0;
    i_data_ok = 1'b0;
    d_addr_ok = 1'b0;
    d_data_ok = 1'b0;
    case (state)
      ADDR: begin
        m_req = 1'b1;
        if (owner == OWN_D) begin
          m_wr      = d_wr;
          m_size    = d_size;
          m_addr    = d_addr;
          m_wdata   = d_wdata;
          d_addr_ok = m_addr_ok;
        end else begin
          m_wr      = i_wr;
          m_size    = i_size;
          m_addr    = i_addr;
          m_wdata   = i_wdata;
          i_addr_ok = m_addr_ok;
        end
      end
      DATA: begin
        if (owner == OWN_D) begin
          d_data_ok = m_data_ok;
        end else begin
          i_data_ok = m_data_ok;
        end
      end
      default: ;
    endcase
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand-written
// stall/reset/fairness sequences, then random traffic against a transaction-level model.
module tb_mem_bus_arbiter;

`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int unsigned SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size, m_size;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_wr      (i_wr),
    .i_size    (i_size),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_addr_ok (i_addr_ok),
    .i_data_ok (i_data_ok),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_size    (d_size),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_addr_ok (d_addr_ok),
    .d_data_ok (d_data_ok),
    .d_rdata   (d_rdata),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_size    (m_size),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_addr_ok (m_addr_ok),
    .m_data_ok (m_data_ok),
    .m_rdata   (m_rdata)
  );

  typedef struct {
    logic        ir, dr, aok, dok;
    logic        e_req, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_ok;  // {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then settle before checking.
  task automatic drive(input logic ir, input logic dr, input logic aok, input logic dok);
    @(negedge clk);
    i_req     = ir;
    d_req     = dr;
    m_addr_ok = aok;
    m_data_ok = dok;
    #1;
  endtask

  function automatic logic [3:0] oks();
    return {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Transaction-level reference for the random phase.
  bit          mdl_busy, mdl_accepted, mdl_own_d;
  int unsigned mdl_waits;

  initial begin
    bit          grants[$];
    bit          i_act, d_act, i_done, d_done;
    logic        e_req;
    logic [66:0] e_fields;
    logic [3:0]  e_ok;
    bit          take_i;

    reset = 1'b1;
    i_req = 0; i_wr = 0; i_size = 2'd2; i_addr = 32'hBFC00000; i_wdata = '0;
    d_req = 0; d_wr = 1; d_size = 2'd2; d_addr = 32'h80000010; d_wdata = 32'hDEADBEEF;
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h3C08BFC0;

    // Reset state: bus acks are present but nothing may respond.
    @(negedge clk); @(negedge clk); #1;
    chk("rst_mreq", m_req, 1'b0);
    chk("rst_ok", oks(), 4'b0000);
    chk("rst_maddr", m_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;

    // Lone fetch, then d/i collision with data store first, with spurious acks.
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hBFC00000, 32'h0,        4'b1000};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0100};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80000010, 32'hDEADBEEF, 4'b0000};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80000010, 32'hDEADBEEF, 4'b0010};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0001};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000};
    vt[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hBFC00000, 32'h0,        4'b1000};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0100};
    for (int unsigned k = 0; k < 13; k++) begin
      drive(vt[k].ir, vt[k].dr, vt[k].aok, vt[k].dok);
      chk($sformatf("vec%0d_mreq", k), m_req, vt[k].e_req);
      chk($sformatf("vec%0d_fields", k), {m_wr, m_size, m_addr, m_wdata},
          {vt[k].e_wr, (vt[k].e_req ? 2'd2 : 2'd0), vt[k].e_addr, vt[k].e_wdata});
      chk($sformatf("vec%0d_ok", k), oks(), vt[k].e_ok);
      if (vt[k].e_ok[2]) chk($sformatf("vec%0d_irdata", k), i_rdata, 32'h3C08BFC0);
    end

    // Bus holds off address accept for 5 cycles.
    d_wr = 1'b0; d_size = 2'd1; d_addr = 32'h12345678; d_wdata = 32'hA5A5A5A5;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 1'b0, k[0]);
      chk("stall_mreq", m_req, 1'b1);
      chk("stall_fields", {m_wr, m_size, m_addr, m_wdata}, {1'b0, 2'd1, 32'h12345678, 32'hA5A5A5A5});
      chk("stall_ok", oks(), 4'b0000);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("stall_accept", oks(), 4'b0010);
    m_rdata = 32'h0BADF00D;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("stall_done", oks(), 4'b0001);
    chk("stall_drdata", d_rdata, 32'h0BADF00D);

    // Reset while in DATA abandons the transaction.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    chk("rstdata_mreq", m_req, 1'b0);
    chk("rstdata_late_ack", oks(), 4'b0000);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rstdata_idle", m_req, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rstdata_owner_d", {m_req, m_addr, oks()}, {1'b1, 32'h12345678, 4'b0010});

    // Both masters held continuously: grant pattern.
    do_reset();
    i_req = 1'b1; d_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1;
    for (int unsigned c = 0; c < 60 && grants.size() < 10; c++) begin
      @(negedge clk); #1;
      if (d_addr_ok) grants.push_back(1'b0);
      if (i_addr_ok) grants.push_back(1'b1);
    end
    if (grants.size() < 10) begin
      chk("grant_timeout", 32'(grants.size()), 32'd10);
    end else begin
      for (int unsigned g = 0; g < 10; g++)
        chk($sformatf("grant%0d_is_i", g), grants[g], FAIR && ((g % (SMAX + 1)) == SMAX));
    end

    // Random traffic against the transaction-level model.
    do_reset();
    mdl_busy = 0; mdl_accepted = 0; mdl_own_d = 1; mdl_waits = 0;
    i_act = 0; d_act = 0; i_done = 0; d_done = 0;
    for (int unsigned c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (i_done) i_act = 0;
      if (d_done) d_act = 0;
      if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1; i_wr = 1'($urandom); i_size = 2'($urandom_range(0, 2));
        i_addr = $urandom; i_wdata = $urandom;
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1; d_wr = 1'($urandom); d_size = 2'($urandom_range(0, 2));
        d_addr = $urandom; d_wdata = $urandom;
      end
      i_req = i_act; d_req = d_act;
      m_addr_ok = 1'($urandom); m_data_ok = 1'($urandom); m_rdata = $urandom;
      #1;
      e_req    = mdl_busy && !mdl_accepted;
      e_fields = !e_req ? 67'h0 :
                 mdl_own_d ? {d_wr, d_size, d_addr, d_wdata} : {i_wr, i_size, i_addr, i_wdata};
      e_ok     = {e_req && !mdl_own_d && m_addr_ok,
                  mdl_busy && mdl_accepted && !mdl_own_d && m_data_ok,
                  e_req && mdl_own_d && m_addr_ok,
                  mdl_busy && mdl_accepted && mdl_own_d && m_data_ok};
      chk("rnd_mreq", m_req, e_req);
      chk("rnd_fields", {m_wr, m_size, m_addr, m_wdata}, e_fields);
      chk("rnd_ok", oks(), e_ok);
      chk("rnd_rdata", {i_rdata, d_rdata}, {m_rdata, m_rdata});
      i_done = e_ok[3];
      d_done = e_ok[1];
      if (!mdl_busy) begin
        if (i_req || d_req) begin
          take_i = i_req && (!d_req || (FAIR && mdl_waits == SMAX));
          mdl_own_d = !take_i;
          if (take_i) mdl_waits = 0;
          else if (i_req) mdl_waits++;
          mdl_busy = 1; mdl_accepted = 0;
        end
      end else if (!mdl_accepted) begin
        if (m_addr_ok) mdl_accepted = 1;
      end else if (m_data_ok) begin
        mdl_busy = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
